// File: rtl/aes_pkg.sv
// Shared AES-256 constants, round-key type, S-box and rcon lookup.
package aes_pkg;
   localparam int NR_256 = 14;
   localparam int NK_256 = 8;

   typedef logic [127:0] round_key_t;

   // Entry 0 sits in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Table lookup keeps the round constant free of any GF doubling chain.
   function automatic logic [31:0] rcon(input logic [2:0] idx);
      logic [31:0] r;
      case (idx)
         3'd1:    r = 32'h0100_0000;
         3'd2:    r = 32'h0200_0000;
         3'd3:    r = 32'h0400_0000;
         3'd4:    r = 32'h0800_0000;
         3'd5:    r = 32'h1000_0000;
         3'd6:    r = 32'h2000_0000;
         3'd7:    r = 32'h4000_0000;
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction
endpackage

// File: rtl/key_expansion_256.sv
// One AES-256 key-expansion step: eight new words from the previous eight.
module key_expansion_256
   import aes_pkg::*;
(
   input  logic [255:0] key_i,
   input  logic [31:0]  rcon_i,
   output logic [255:0] key_o
);
   logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
   logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
   logic [31:0] t0, t1;

   assign {w0, w1, w2, w3, w4, w5, w6, w7} = key_i;

   assign t0 = sub_word({w7[23:0], w7[31:24]}) ^ rcon_i;
   assign n0 = w0 ^ t0;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   // Nk=8 adds a plain SubWord (no rotate, no rcon) halfway through.
   assign t1 = sub_word(n3);
   assign n4 = w4 ^ t1;
   assign n5 = w5 ^ n4;
   assign n6 = w6 ^ n5;
   assign n7 = w7 ^ n6;

   assign key_o = {n0, n1, n2, n3, n4, n5, n6, n7};
endmodule

// File: rtl/key_schedule_256_seq.sv
// Sequential AES-256 key schedule: seven expansion steps fill 15 round keys
// that are served through a registered read port.
//
// state     | meaning
// ST_IDLE   | after reset, no key loaded
// ST_EXPAND | iterations 1..7 running, busy
// ST_READY  | all round keys valid, accepts a new start
module key_schedule_256_seq
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [255:0] key_in,
   output logic         busy,
   output logic         keys_valid,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EXPAND = 2'd1;
   localparam logic [1:0] ST_READY  = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [2:0]   iter_q, iter_d;
   logic [255:0] key_q, key_d;
   logic         valid_q, valid_d;
   logic [255:0] exp_key;
   logic         accept;
   logic         expanding;
   round_key_t   rk_q [0:NR_256];
   round_key_t   rd_key_q, rd_key_d;

   key_expansion_256 u_key_expansion (
      .key_i  (key_q),
      .rcon_i (rcon(iter_q)),
      .key_o  (exp_key)
   );

   assign expanding = (state_q == ST_EXPAND);
   assign accept    = start && !expanding;

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      key_d   = key_q;
      valid_d = valid_q;
      if (accept) begin
         state_d = ST_EXPAND;
         iter_d  = 3'd1;
         key_d   = key_in;
         valid_d = 1'b0;
      end else if (expanding) begin
         key_d = exp_key;
         if (iter_q == 3'd7) begin
            state_d = ST_READY;
            valid_d = 1'b1;
         end else begin
            iter_d = iter_q + 3'd1;
         end
      end
   end

   always_comb begin
      rd_key_d = '0;
      if (rd_idx != 4'd15) rd_key_d = rk_q[rd_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         iter_q   <= 3'd0;
         key_q    <= '0;
         valid_q  <= 1'b0;
         rd_key_q <= '0;
      end else begin
         state_q  <= state_d;
         iter_q   <= iter_d;
         key_q    <= key_d;
         valid_q  <= valid_d;
         rd_key_q <= rd_key_d;
      end
   end

   // Iteration i lands in rk[2i] and rk[2i+1]; the last one only fills rk[14].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= NR_256; i++) rk_q[i] <= '0;
      end else if (accept) begin
         rk_q[0] <= key_in[255:128];
         rk_q[1] <= key_in[127:0];
      end else if (expanding) begin
         rk_q[{iter_q, 1'b0}] <= exp_key[255:128];
         if (iter_q != 3'd7) rk_q[{iter_q, 1'b1}] <= exp_key[127:0];
      end
   end

   assign busy       = expanding;
   assign keys_valid = valid_q;
   assign rd_key     = rd_key_q;
endmodule

// File: tb/tb_key_schedule_256_seq.sv
// Self-checking bench for key_schedule_256_seq against a word-level
// FIPS-197 key expansion model with a GF(2^8)-derived S-box.
module tb_key_schedule_256_seq;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [255:0] key_in;
   logic         busy;
   logic         keys_valid;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [7:0]   sbox_t [0:255];
   logic [127:0] exp_rk [0:14];

   localparam logic [255:0] KEY_A3 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] KEY_C3 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   key_schedule_256_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .key_in     (key_in),
      .busy       (busy),
      .keys_valid (keys_valid),
      .rd_idx     (rd_idx),
      .rd_key     (rd_key)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xt(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   function automatic logic [255:0] rand_key();
      logic [255:0] k;
      k = '0;
      for (int i = 0; i < 8; i++) k = {k[223:0], 32'($urandom())};
      return k;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         if (a != 0) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(a));
         end
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox_t[a] = s;
      end
   endtask

   task automatic model_expand(input logic [255:0] k);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (i % 8 == 4) begin
            t = subw(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int n = 0; n < 15; n++) exp_rk[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
   endtask

   task automatic read_key(input logic [3:0] idx, output logic [127:0] v);
      @(negedge clk) rd_idx = idx;
      @(negedge clk) v = rd_key;
   endtask

   // Pulses start with k; returns edges from the accept edge (counted as 1) to keys_valid.
   task automatic run_start(input logic [255:0] k, output int edges);
      @(negedge clk);
      start = 1'b1; key_in = k;
      @(negedge clk);
      start = 1'b0; key_in = rand_key();
      edges = 1;
      while (!keys_valid && edges < 20) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic test_reset();
      logic [127:0] v;
      rst_n = 1'b0; start = 1'b0; key_in = '0; rd_idx = 4'd0;
      repeat (3) @(negedge clk);
      vec_cnt++;
      if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vec_cnt++;
      if (keys_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", keys_valid); end
      vec_cnt++;
      if (rd_key !== 128'h0) begin err_cnt++; $display("FAIL reset_rd_key: got %h expected 0", rd_key); end
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         read_key(4'(i), v);
         vec_cnt++;
         if (v !== 128'h0) begin err_cnt++; $display("FAIL reset_rk[%0d]: got %h expected 0", i, v); end
      end
   endtask

   task automatic test_fips_a3();
      int edges;
      logic [127:0] v;
      model_expand(KEY_A3);
      run_start(KEY_A3, edges);
      vec_cnt++;
      if (edges !== 8) begin err_cnt++; $display("FAIL a3_latency: got %0d expected 8", edges); end
      vec_cnt++;
      if (busy !== 1'b0) begin err_cnt++; $display("FAIL a3_busy_done: got %b expected 0", busy); end
      for (int n = 0; n < 15; n++) begin
         read_key(4'(n), v);
         vec_cnt++;
         if (v !== exp_rk[n]) begin err_cnt++; $display("FAIL a3_rk[%0d]: got %h expected %h", n, v, exp_rk[n]); end
         if (n == 2) begin
            vec_cnt++;
            if (v !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin
               err_cnt++; $display("FAIL a3_fips_rk2: got %h expected 9ba354118e6925afa51a8b5f2067fcde", v);
            end
         end
         if (n == 14) begin
            vec_cnt++;
            if (v !== 128'hfe4890d1e6188d0b046df344706c631e) begin
               err_cnt++; $display("FAIL a3_fips_rk14: got %h expected fe4890d1e6188d0b046df344706c631e", v);
            end
         end
      end
   endtask

   task automatic test_restart_c3();
      int edges;
      logic [127:0] v;
      model_expand(KEY_C3);
      @(negedge clk);
      start = 1'b1; key_in = KEY_C3;
      @(negedge clk);
      start = 1'b0;
      vec_cnt++;
      if (keys_valid !== 1'b0 || busy !== 1'b1) begin
         err_cnt++; $display("FAIL c3_accept: got valid=%b busy=%b expected valid=0 busy=1", keys_valid, busy);
      end
      edges = 1;
      while (!keys_valid && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      vec_cnt++;
      if (edges !== 8) begin err_cnt++; $display("FAIL c3_latency: got %0d expected 8", edges); end
      for (int n = 0; n < 15; n++) begin
         read_key(4'(n), v);
         vec_cnt++;
         if (v !== exp_rk[n]) begin err_cnt++; $display("FAIL c3_rk[%0d]: got %h expected %h", n, v, exp_rk[n]); end
         if (n == 0) begin
            vec_cnt++;
            if (v !== 128'h000102030405060708090a0b0c0d0e0f) begin
               err_cnt++; $display("FAIL c3_fips_rk0: got %h expected 000102030405060708090a0b0c0d0e0f", v);
            end
         end
         if (n == 14) begin
            vec_cnt++;
            if (v !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
               err_cnt++; $display("FAIL c3_fips_rk14: got %h expected 24fc79ccbf0979e9371ac23c6d68de36", v);
            end
         end
      end
      read_key(4'd15, v);
      vec_cnt++;
      if (v !== 128'h0) begin err_cnt++; $display("FAIL c3_idx15: got %h expected 0", v); end
   endtask

   task automatic test_ignore_start();
      int edges;
      logic [127:0] v;
      logic [255:0] k1, k2;
      k1 = rand_key(); k2 = rand_key();
      model_expand(k1);
      @(negedge clk);
      start = 1'b1; key_in = k1;
      @(negedge clk);
      edges = 1;
      while (!keys_valid && edges < 20) begin
         start  = (edges == 2 || edges == 5);
         key_in = start ? k2 : k1;
         @(negedge clk);
         edges++;
      end
      start = 1'b0;
      vec_cnt++;
      if (edges !== 8) begin err_cnt++; $display("FAIL ignore_latency: got %0d expected 8", edges); end
      vec_cnt++;
      if (busy !== 1'b0) begin err_cnt++; $display("FAIL ignore_busy: got %b expected 0", busy); end
      for (int n = 0; n < 15; n++) begin
         read_key(4'(n), v);
         vec_cnt++;
         if (v !== exp_rk[n]) begin err_cnt++; $display("FAIL ignore_rk[%0d]: got %h expected %h", n, v, exp_rk[n]); end
      end
   endtask

   task automatic test_sweep();
      logic [127:0 ] exp;
      @(negedge clk) rd_idx = 4'd0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         exp = (i - 1 < 15) ? exp_rk[i-1] : 128'h0;
         vec_cnt++;
         if (rd_key !== exp) begin err_cnt++; $display("FAIL sweep_idx%0d: got %h expected %h", i - 1, rd_key, exp); end
         if (i < 16) rd_idx = 4'(i);
      end
   endtask

   task automatic test_reset_mid();
      int edges;
      logic [127:0] v;
      logic [255:0] k;
      k = rand_key();
      @(negedge clk);
      rd_idx = 4'd2; start = 1'b1; key_in = k;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (busy !== 1'b0 || keys_valid !== 1'b0 || rd_key !== 128'h0) begin
         err_cnt++;
         $display("FAIL midreset_outputs: got busy=%b valid=%b rd_key=%h expected all 0", busy, keys_valid, rd_key);
      end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         read_key(4'(i), v);
         vec_cnt++;
         if (v !== 128'h0) begin err_cnt++; $display("FAIL midreset_rk[%0d]: got %h expected 0", i, v); end
      end
      k = rand_key();
      model_expand(k);
      run_start(k, edges);
      vec_cnt++;
      if (edges !== 8) begin err_cnt++; $display("FAIL midreset_latency: got %0d expected 8", edges); end
      for (int n = 0; n < 15; n++) begin
         read_key(4'(n), v);
         vec_cnt++;
         if (v !== exp_rk[n]) begin err_cnt++; $display("FAIL midreset_rk_new[%0d]: got %h expected %h", n, v, exp_rk[n]); end
      end
   endtask

   task automatic test_back_to_back();
      int edges;
      logic [127:0] v;
      logic [255:0] k;
      for (int r = 0; r < 4; r++) begin
         k = rand_key();
         model_expand(k);
         run_start(k, edges);
         vec_cnt++;
         if (edges !== 8) begin err_cnt++; $display("FAIL b2b%0d_latency: got %0d expected 8", r, edges); end
         for (int n = 0; n < 15; n++) begin
            read_key(4'(n), v);
            vec_cnt++;
            if (v !== exp_rk[n]) begin err_cnt++; $display("FAIL b2b%0d_rk[%0d]: got %h expected %h", r, n, v, exp_rk[n]); end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      build_sbox();
      test_reset();
      test_fips_a3();
      test_restart_c3();
      test_ignore_start();
      test_sweep();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
